// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the core/DMA requesters, the data memory and the arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_stall;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_lock;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  d_req, d_we, d_addr, d_wdata, d_lock,
    input  mem_rdata,
    output c_gnt, c_stall, c_rvalid, c_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output d_req, d_we, d_addr, d_wdata, d_lock,
    output mem_rdata,
    input  c_gnt, c_stall, c_rvalid, c_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core and a DMA
// master, with a bounded DMA burst lock and one-cycle registered read return.
module dmem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input logic                clk,
  input logic                rst_n,
  dmem_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {IDLE = 2'd0, CORE = 2'd1, DMA = 2'd2} owner_t;

  owner_t            owner;
  owner_t            last;
  logic [CNT_W-1:0]  burst_cnt;
  logic              lock_hold;
  logic              gnt_c;
  logic              gnt_d;
  logic              c_rvalid_q;
  logic              d_rvalid_q;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  // Grants are combinational and forced low while reset is held.
  always_comb begin
    lock_hold = (owner == DMA) && bus.d_lock && (burst_cnt < BURST_MAX);
    gnt_c     = 1'b0;
    gnt_d     = 1'b0;
    if (rst_n) begin
      if (bus.c_req && bus.d_req) begin
        if (lock_hold || (last == CORE)) gnt_d = 1'b1;
        else                             gnt_c = 1'b1;
      end else begin
        gnt_c = bus.c_req;
        gnt_d = bus.d_req;
      end
    end
  end

  assign bus.c_gnt     = gnt_c;
  assign bus.d_gnt     = gnt_d;
  assign bus.c_stall   = rst_n & bus.c_req & ~gnt_c;
  assign bus.mem_we    = gnt_c ? bus.c_we    : (gnt_d ? bus.d_we    : 1'b0);
  assign bus.mem_addr  = gnt_c ? bus.c_addr  : (gnt_d ? bus.d_addr  : {ADDR_W{1'b0}});
  assign bus.mem_wdata = gnt_c ? bus.c_wdata : (gnt_d ? bus.d_wdata : {DATA_W{1'b0}});
  assign bus.c_rvalid  = c_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.c_rdata   = c_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= IDLE;
      last       <= CORE;
      burst_cnt  <= '0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      owner <= gnt_d ? DMA : (gnt_c ? CORE : IDLE);
      if (gnt_d)      last <= DMA;
      else if (gnt_c) last <= CORE;

      // Burst length only grows across back-to-back DMA grants.
      if (gnt_d) begin
        if (owner == DMA) begin
          if (burst_cnt < BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
        end else begin
          burst_cnt <= CNT_W'(1);
        end
      end else begin
        burst_cnt <= '0;
      end

      c_rvalid_q <= gnt_c & ~bus.c_we;
      d_rvalid_q <= gnt_d & ~bus.d_we;
      if (gnt_c && !bus.c_we) c_rdata_q <= bus.mem_rdata;
      if (gnt_d && !bus.d_we) d_rdata_q <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed plus randomized bench for dmem_port_arbiter against a rule-level
// model with its own shadow copy of the data memory.
module tb_dmem_port_arbiter;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;
  localparam int NONE = 0;
  localparam int CORE = 1;
  localparam int DMA  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] mem    [0:255];
  logic [31:0] shadow [0:255];
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  int errors = 0;
  int checks = 0;

  int          m_owner, m_last, m_burst;
  logic        m_c_rv, m_d_rv;
  logic [31:0] m_c_rd, m_d_rd;
  int          obs_log[$];
  int          stall_run, max_stall;

  logic        c_pend, c_we_r, d_pend, d_we_r;
  logic [31:0] c_addr_r, c_wd_r, d_addr_r, d_wd_r;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                               input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                               input logic dl);
    bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
    bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
    bus.d_lock = dl;
  endtask

  task automatic modelReset();
    m_owner = NONE; m_last = CORE; m_burst = 0;
    m_c_rv = 1'b0; m_d_rv = 1'b0; m_c_rd = '0; m_d_rd = '0;
  endtask

  // Who wins this cycle, straight from the arbitration rules.
  function automatic int pickGrant();
    if (!bus.c_req && !bus.d_req) return NONE;
    if (bus.c_req && !bus.d_req)  return CORE;
    if (!bus.c_req && bus.d_req)  return DMA;
    if (m_owner == DMA && bus.d_lock && m_burst < MAX_BURST) return DMA;
    return (m_last == CORE) ? DMA : CORE;
  endfunction

  // Inputs already applied; check mid-cycle, then advance model across the edge.
  task automatic stepCycle(output int g);
    logic        ew, wr;
    logic [31:0] ea, ed, wa, wd;
    @(negedge clk);
    g  = pickGrant();
    ew = 1'b0; ea = '0; ed = '0;
    if (g == CORE)     begin ew = bus.c_we; ea = bus.c_addr; ed = bus.c_wdata; end
    else if (g == DMA) begin ew = bus.d_we; ea = bus.d_addr; ed = bus.d_wdata; end
    obs_log.push_back(bus.d_gnt ? DMA : (bus.c_gnt ? CORE : NONE));
    checkOutput("c_gnt",     32'(bus.c_gnt),    32'(g == CORE));
    checkOutput("d_gnt",     32'(bus.d_gnt),    32'(g == DMA));
    checkOutput("c_stall",   32'(bus.c_stall),  32'(bus.c_req && g != CORE));
    checkOutput("mem_we",    32'(bus.mem_we),   32'(ew));
    checkOutput("mem_addr",  bus.mem_addr,      ea);
    checkOutput("mem_wdata", bus.mem_wdata,     ed);
    checkOutput("c_rvalid",  32'(bus.c_rvalid), 32'(m_c_rv));
    checkOutput("d_rvalid",  32'(bus.d_rvalid), 32'(m_d_rv));
    checkOutput("c_rdata",   bus.c_rdata,       m_c_rd);
    checkOutput("d_rdata",   bus.d_rdata,       m_d_rd);
    if (bus.c_stall) stall_run++; else stall_run = 0;
    if (stall_run > max_stall) max_stall = stall_run;
    wr = bus.mem_we; wa = bus.mem_addr; wd = bus.mem_wdata;
    @(posedge clk);
    m_c_rv = 1'b0;
    m_d_rv = 1'b0;
    if (g == CORE) begin
      if (!bus.c_we) begin m_c_rv = 1'b1; m_c_rd = shadow[bus.c_addr[7:0]]; end
      else shadow[bus.c_addr[7:0]] = bus.c_wdata;
    end else if (g == DMA) begin
      if (!bus.d_we) begin m_d_rv = 1'b1; m_d_rd = shadow[bus.d_addr[7:0]]; end
      else shadow[bus.d_addr[7:0]] = bus.d_wdata;
    end
    if (g == DMA) m_burst = (m_owner == DMA) ? ((m_burst < MAX_BURST) ? m_burst + 1 : MAX_BURST) : 1;
    else          m_burst = 0;
    m_owner = g;
    if (g != NONE) m_last = g;
    #1;
    if (wr) mem[wa[7:0]] = wd;
  endtask

  // Requesters hold their request until granted. lock_mode: 0 off, 1 on, 2 random.
  task automatic runTraffic(input int cycles, input int c_rate, input int d_rate,
                            input int lock_mode, input bit allow_write);
    int g;
    for (int i = 0; i < cycles; i++) begin
      if (!c_pend && $urandom_range(99) < c_rate) begin
        c_pend = 1'b1; c_we_r = allow_write & $urandom_range(1);
        c_addr_r = $urandom_range(255); c_wd_r = $urandom;
      end
      if (!d_pend && $urandom_range(99) < d_rate) begin
        d_pend = 1'b1; d_we_r = allow_write & $urandom_range(1);
        d_addr_r = $urandom_range(255); d_wd_r = $urandom;
      end
      applyStimulus(c_pend, c_we_r, c_addr_r, c_wd_r, d_pend, d_we_r, d_addr_r, d_wd_r,
                    (lock_mode == 2) ? 1'($urandom_range(1)) : 1'(lock_mode == 1));
      stepCycle(g);
      if (g == CORE) c_pend = 1'b0;
      if (g == DMA)  d_pend = 1'b0;
    end
  endtask

  initial begin
    int g;
    int rr_exp[4];
    int lk_exp[10];
    logic [31:0] v;
    rr_exp = '{DMA, CORE, DMA, CORE};
    lk_exp = '{DMA, DMA, DMA, DMA, CORE, DMA, DMA, DMA, DMA, CORE};
    for (int i = 0; i < 256; i++) begin
      v = $urandom; mem[i] = v; shadow[i] = v;
    end
    mem[8'h10] = 32'hDEADBEEF; shadow[8'h10] = 32'hDEADBEEF;
    c_pend = 1'b0; d_pend = 1'b0; stall_run = 0; max_stall = 0;

    // Reset held with both requesting: every output must be forced low.
    rst_n = 1'b0;
    modelReset();
    applyStimulus(1'b1, 1'b1, 32'h44, 32'h1, 1'b1, 1'b1, 32'h48, 32'h2, 1'b1);
    #3;
    checkOutput("rst_c_gnt",    32'(bus.c_gnt),    32'd0);
    checkOutput("rst_d_gnt",    32'(bus.d_gnt),    32'd0);
    checkOutput("rst_c_stall",  32'(bus.c_stall),  32'd0);
    checkOutput("rst_mem_we",   32'(bus.mem_we),   32'd0);
    checkOutput("rst_mem_addr", bus.mem_addr,      32'd0);
    checkOutput("rst_c_rvalid", 32'(bus.c_rvalid), 32'd0);
    checkOutput("rst_d_rdata",  bus.d_rdata,       32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single core read returns the stored word one cycle later.
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    stepCycle(g);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    stepCycle(g);
    checkOutput("read_c_rdata", bus.c_rdata, 32'hDEADBEEF);

    // Continuous reads from both sides alternate, DMA first.
    obs_log.delete();
    runTraffic(4, 100, 100, 0, 1'b0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("rr_seq%0d", i), obs_log[i], rr_exp[i]);

    // Locked burst is capped at MAX_BURST grants before the core gets one.
    obs_log.delete();
    runTraffic(12, 100, 100, 1, 1'b0);
    for (int i = 0; i < 10; i++) checkOutput($sformatf("lock_seq%0d", i), obs_log[i], lk_exp[i]);

    // DMA write then core read of the same word.
    c_pend = 1'b0; d_pend = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0);
    stepCycle(g);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    stepCycle(g);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    stepCycle(g);
    checkOutput("wr_rd_c_rdata", bus.c_rdata, 32'h12345678);

    // Build a two-deep DMA burst with a read in flight, then reset asynchronously.
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1);
    stepCycle(g);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h34, 32'h0, 1'b1);
    stepCycle(g);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h38, 32'h0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("arst_c_gnt",    32'(bus.c_gnt),    32'd0);
    checkOutput("arst_d_gnt",    32'(bus.d_gnt),    32'd0);
    checkOutput("arst_c_stall",  32'(bus.c_stall),  32'd0);
    checkOutput("arst_mem_addr", bus.mem_addr,      32'd0);
    checkOutput("arst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    checkOutput("arst_d_rdata",  bus.d_rdata,       32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    obs_log.delete();
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h38, 32'h0, 1'b0);
    stepCycle(g);
    checkOutput("post_rst_tie", obs_log[0], DMA);

    // Three idle cycles.
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) stepCycle(g);

    // Randomized mixed traffic with random lock.
    c_pend = 1'b0; d_pend = 1'b0; max_stall = 0; stall_run = 0;
    runTraffic(400, 70, 70, 2, 1'b1);
    checkOutput("max_core_stall_ok", 32'(max_stall <= MAX_BURST), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
